// File: rtl/dpram_arb_pkg.sv
// Shared types and helpers for the dual-port RAM port arbiter.
// Optional build macro: DPRAM_ARB_FIXED_PRIO_EN (see rr_arbiter).
package dpram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = $clog2(MAX_REQ);

  // Encode a one-hot (or all-zero) vector as a binary index.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] i_oh);
    logic [IDX_W-1:0] v_idx;
    v_idx = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (i_oh[i]) v_idx = v_idx | IDX_W'(i);
    end
    return v_idx;
  endfunction

endpackage

// File: rtl/dpram_port_arbiter_rr.sv
// Combinational round-robin pick for the RAM port arbiter.
// With DPRAM_ARB_FIXED_PRIO_EN defined, requester 0 always wins and the
// remaining requesters rotate among themselves when requester 0 is idle.
module rr_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  int unsigned w_start;
  int unsigned w_dist;
  int unsigned w_best;
  int unsigned w_win;

  // Pick the requester with the smallest upward distance from the pointer.
  always_comb begin
    w_start = 32'(i_rr_ptr);
    w_dist  = 0;
    w_best  = NUM_REQ;
    w_win   = 0;
`ifdef DPRAM_ARB_FIXED_PRIO_EN
    // Pointer value 0 means "start of the rotating group", i.e. requester 1.
    if (w_start == 0) w_start = 1;
    if (i_req[0]) begin
      w_win  = 0;
      w_best = 0;
    end else begin
      for (int unsigned i = 1; i < NUM_REQ; i++) begin
        if (i_req[i]) begin
          w_dist = (i >= w_start) ? (i - w_start) : (i + NUM_REQ - 1 - w_start);
          if (w_dist < w_best) begin
            w_best = w_dist;
            w_win  = i;
          end
        end
      end
    end
`else
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (i_req[i]) begin
        w_dist = (i >= w_start) ? (i - w_start) : (i + NUM_REQ - w_start);
        if (w_dist < w_best) begin
          w_best = w_dist;
          w_win  = i;
        end
      end
    end
`endif
    o_valid = |i_req;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      o_gnt[i] = o_valid && (w_win == i);
    end
    o_idx = onehot_to_idx(MAX_REQ'(o_gnt));
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Shares one port of a dual-port RAM between NUM_REQ clients with
// round-robin arbitration, and owns a sequencer that fills the RAM with
// CLEAR_VALUE on request. Optional macro: DPRAM_ARB_FIXED_PRIO_EN.
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int unsigned           NUM_REQ       = 4,
  parameter int unsigned           ADDRESS_WIDTH = 10,
  parameter int unsigned           DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               we,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               rvalid,
  output logic [DATA_WIDTH-1:0]            rdata,
  input  logic                             clear_start,
  output logic                             clear_busy,
  output logic                             clear_done,
  output logic                             ram_wren,
  output logic [ADDRESS_WIDTH-1:0]         ram_address,
  output logic [DATA_WIDTH-1:0]            ram_data,
  input  logic [DATA_WIDTH-1:0]            ram_q
);

  arb_state_t               r_state;
  arb_state_t               w_next_state;
  logic [ADDRESS_WIDTH-1:0] r_clr_cnt;
  logic [IDX_W-1:0]         r_rr_ptr;
  logic [NUM_REQ-1:0]       r_rvalid;

  logic [NUM_REQ-1:0]       w_arb_gnt;
  logic [IDX_W-1:0]         w_arb_idx;
  logic                     w_arb_valid;
  logic                     w_idle;

  assign w_idle = (r_state == IDLE);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .i_req    (req),
    .i_rr_ptr (r_rr_ptr),
    .o_gnt    (w_arb_gnt),
    .o_idx    (w_arb_idx),
    .o_valid  (w_arb_valid)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic: clear request accepted only from IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (clear_start) w_next_state = CLEAR;
      CLEAR:   if (r_clr_cnt == '1) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Clear address counter; natural wrap returns it to 0 as CLEAR ends.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)               r_clr_cnt <= '0;
    else if (r_state == CLEAR)  r_clr_cnt <= r_clr_cnt + 1'b1;
  end

  // Round-robin pointer moves past the winner of every granted access.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr <= '0;
    end else if (w_idle && w_arb_valid) begin
      r_rr_ptr <= (w_arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_arb_idx + 1'b1;
    end
  end

  // Read-valid pipeline: one cycle behind the grant, matching RAM latency.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_rvalid <= '0;
    else          r_rvalid <= w_idle ? (w_arb_gnt & ~we) : '0;
  end

  assign rvalid = r_rvalid;
  assign rdata  = ram_q;

  // Output decode: grant mux in IDLE, sequential fill in CLEAR.
  // Grants are also gated by reset_n so an asserted reset silences the port
  // immediately, not only at the next edge.
  always_comb begin
    gnt         = '0;
    ram_wren    = 1'b0;
    ram_address = '0;
    ram_data    = '0;
    clear_busy  = 1'b0;
    clear_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (reset_n) begin
          gnt = w_arb_gnt;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_arb_gnt[i]) begin
              ram_wren    = we[i];
              ram_address = addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
              ram_data    = wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
      end
      CLEAR: begin
        clear_busy  = 1'b1;
        ram_wren    = 1'b1;
        ram_address = r_clr_cnt;
        ram_data    = CLEAR_VALUE;
      end
      DONE: begin
        clear_busy = 1'b1;
        clear_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
